// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - input/output stream bundle for the immediate-extension stage
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extension with one-entry skid buffer
// Optional feature macro: EXT_BRANCH_SHIFT_EN (mode 11 sign-extends then shifts left by 2).
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    imm_extend_pipe_if.slave bus
);
    localparam int PAD_W = OUT_W - IN_W;

    logic             or_valid_q, or_valid_d;
    logic [OUT_W-1:0] or_data_q,  or_data_d;
    logic [TAG_W-1:0] or_tag_q,   or_tag_d;
    logic             sr_valid_q, sr_valid_d;
    logic [OUT_W-1:0] sr_data_q,  sr_data_d;
    logic [TAG_W-1:0] sr_tag_q,   sr_tag_d;

    logic [OUT_W-1:0] ext_zero;
    logic [OUT_W-1:0] ext_sign;
    logic [OUT_W-1:0] ext_upper;
    logic [OUT_W-1:0] ext_data;
    logic             accept;
    logic             xfer;

    // Extension happens before storage so both registers hold final results.
    always_comb begin
        ext_zero  = {{PAD_W{1'b0}}, bus.in_imm};
        ext_sign  = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
        ext_upper = {bus.in_imm, {PAD_W{1'b0}}};
        ext_data  = ext_zero;
        case (bus.in_mode)
            2'b00:   ext_data = ext_zero;
            2'b01:   ext_data = ext_sign;
            2'b10:   ext_data = ext_upper;
`ifdef EXT_BRANCH_SHIFT_EN
            default: ext_data = {ext_sign[OUT_W-3:0], 2'b00};
`else
            default: ext_data = ext_sign;
`endif
        endcase
    end

    assign accept = bus.in_valid & ~sr_valid_q;
    assign xfer   = or_valid_q & bus.out_ready;

    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_tag_d   = or_tag_q;
        sr_valid_d = sr_valid_q;
        sr_data_d  = sr_data_q;
        sr_tag_d   = sr_tag_q;

        if (flush) begin
            // Payload is left untouched so out_data/out_tag hold their last values.
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (!or_valid_q || xfer) begin
            if (sr_valid_q) begin
                or_valid_d = 1'b1;
                or_data_d  = sr_data_q;
                or_tag_d   = sr_tag_q;
                sr_valid_d = 1'b0;
            end else if (accept) begin
                or_valid_d = 1'b1;
                or_data_d  = ext_data;
                or_tag_d   = bus.in_tag;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sr_valid_d = 1'b1;
            sr_data_d  = ext_data;
            sr_tag_d   = bus.in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_tag_q   <= '0;
            sr_valid_q <= 1'b0;
            sr_data_q  <= '0;
            sr_tag_q   <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_tag_q   <= or_tag_d;
            sr_valid_q <= sr_valid_d;
            sr_data_q  <= sr_data_d;
            sr_tag_q   <= sr_tag_d;
        end
    end

    assign bus.in_ready  = ~sr_valid_q;
    assign bus.out_valid = or_valid_q;
    assign bus.out_data  = or_data_q;
    assign bus.out_tag   = or_tag_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench for imm_extend_pipe
module tb_imm_extend_pipe;
    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    beat_t exp_q[$];

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        longint u;
        longint s;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            2'd0:    return 32'(u);
            2'd1:    return 32'(s);
            2'd2:    return 32'(u * 65536);
`ifdef EXT_BRANCH_SHIFT_EN
            default: return 32'(s * 4);
`else
            default: return 32'(s);
`endif
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic ordy, input logic fl);
        beat_t b;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_imm    = imm;
        bus.in_mode   = mode;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        if (v && bus.in_ready && !fl) begin
            b.data = model(imm, mode);
            b.tag  = tag;
            exp_q.push_back(b);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 2'd0, 5'd0, ordy, 1'b0);
    endtask

    // Monitor: a transfer is committed at the next rising edge, so it is judged here.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {27'd0, bus.out_tag}, 32'hFFFFFFFF);
                    end else begin
                        b = exp_q.pop_front();
                        chk("sb_data", bus.out_data, b.data);
                        chk("sb_tag", {27'd0, bus.out_tag}, {27'd0, b.tag});
                    end
                end
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        logic [31:0] exp_ffff;
        logic [31:0] exp_0040;
`ifdef EXT_BRANCH_SHIFT_EN
        exp_ffff = 32'hFFFFFFFC;
        exp_0040 = 32'h00000100;
`else
        exp_ffff = 32'hFFFFFFFF;
        exp_0040 = 32'h00000040;
`endif
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        // Mode sweep
        step(1'b1, 16'h8001, 2'd0, 5'd3, 1'b1, 1'b0);
        step(1'b1, 16'h8001, 2'd1, 5'd4, 1'b1, 1'b0);
        chk("zero_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("zero_data", bus.out_data, 32'h00008001);
        chk("zero_tag", {27'd0, bus.out_tag}, 32'd3);
        step(1'b1, 16'h1234, 2'd2, 5'd5, 1'b1, 1'b0);
        chk("sign_data", bus.out_data, 32'hFFFF8001);
        chk("sign_tag", {27'd0, bus.out_tag}, 32'd4);
        step(1'b1, 16'hFFFF, 2'd3, 5'd6, 1'b1, 1'b0);
        chk("upper_data", bus.out_data, 32'h12340000);
        step(1'b1, 16'h0040, 2'd3, 5'd7, 1'b1, 1'b0);
        chk("branch_ffff", bus.out_data, exp_ffff);
        idle(1'b1);
        chk("branch_0040", bus.out_data, exp_0040);
        idle(1'b1);
        chk("sweep_idle", {31'd0, bus.out_valid}, 32'd0);

        // Back-pressure
        step(1'b1, 16'h0101, 2'd1, 5'd1, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 2'd0, 5'd2, 1'b0, 1'b0);
        chk("bp_or_tag1", {27'd0, bus.out_tag}, 32'd1);
        chk("bp_ready_before_sr", {31'd0, bus.in_ready}, 32'd1);
        step(1'b1, 16'h0303, 2'd2, 5'd3, 1'b0, 1'b0);
        chk("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold_tag1", {27'd0, bus.out_tag}, 32'd1);
        step(1'b1, 16'h0303, 2'd2, 5'd3, 1'b0, 1'b0);
        chk("bp_ready_low2", {31'd0, bus.in_ready}, 32'd0);
        step(1'b1, 16'h0303, 2'd2, 5'd3, 1'b1, 1'b0);
        chk("bp_out1", {27'd0, bus.out_tag}, 32'd1);
        step(1'b1, 16'h0303, 2'd2, 5'd3, 1'b1, 1'b0);
        chk("bp_out2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_out2", {27'd0, bus.out_tag}, 32'd2);
        chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
        idle(1'b1);
        chk("bp_out3_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_out3", {27'd0, bus.out_tag}, 32'd3);
        idle(1'b1);
        chk("bp_idle", {31'd0, bus.out_valid}, 32'd0);

        // Streaming
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'($urandom), 2'($urandom), 5'(i), 1'b1, 1'b0);
            chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
            if (i > 0) chk("stream_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        idle(1'b1);
        chk("stream_last_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stream_last_tag", {27'd0, bus.out_tag}, 32'd19);
        idle(1'b1);
        chk("stream_idle", {31'd0, bus.out_valid}, 32'd0);

        // Flush with OR and SR full
        step(1'b1, 16'hAAAA, 2'd0, 5'd10, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 2'd1, 5'd11, 1'b0, 1'b0);
        step(1'b1, 16'hCCCC, 2'd2, 5'd12, 1'b0, 1'b1);
        chk("flush_sr_full", {31'd0, bus.in_ready}, 32'd0);
        idle(1'b0);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        // Flush discarding a beat accepted in the same cycle
        step(1'b1, 16'hDDDD, 2'd0, 5'd13, 1'b0, 1'b0);
        step(1'b1, 16'hEEEE, 2'd1, 5'd14, 1'b0, 1'b1);
        idle(1'b1);
        chk("flush2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush2_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Asynchronous reset mid-stream
        step(1'b1, 16'h1111, 2'd1, 5'd20, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 2'd1, 5'd21, 1'b0, 1'b0);
        idle(1'b0);
        chk("rstm_full", {31'd0, bus.in_ready}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("rstm_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstm_out_data", bus.out_data, 32'd0);
        chk("rstm_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.delete();
        #1;
        rst = 1'b0;
        step(1'b1, 16'h9876, 2'd1, 5'd22, 1'b1, 1'b0);
        idle(1'b1);
        chk("rstm_next_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("rstm_next_data", bus.out_data, 32'hFFFF9876);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), 2'($urandom), 5'($urandom),
                 ($urandom % 4) != 0, ($urandom % 40) == 0);
        end
        for (int k = 0; k < 10; k++) begin
            idle(1'b1);
            #3;
            if (exp_q.size() == 0) break;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(1'b1);
        chk("final_idle", {31'd0, bus.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
